// File: rtl/grf_trace.sv
// Small circular FIFO with occupancy count; head entry is visible combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: in_rdy drops when full, unless the head is popped in the same cycle.
module grf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   core_clk,
    input  logic                   arst_n,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [W-1:0]           in_dat,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [W-1:0]           out_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;

    assign full    = (count == FULL_CNT);
    assign out_vld = (count != '0);
    assign pop     = out_vld & out_rdy;
    assign in_rdy  = ~full | pop;
    assign push    = in_vld & in_rdy;
    assign out_dat = mem[head];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) mem[tail] <= in_dat;
    end
endmodule

// 32x32 register file with write-through bypass and a write-back trace FIFO.
// Latency: reads combinational; trace record at FIFO head one cycle after the write.
// Backpressure: stall when the trace FIFO is full; writes then drop unless the head pops.
module grf_trace #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [4:0]             waddr,
    input  logic [31:0]            wdata,
    input  logic [31:0]            wpc,
    input  logic [4:0]             raddr1,
    input  logic [4:0]             raddr2,
    output logic [31:0]            rdata1,
    output logic [31:0]            rdata2,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [31:0]            trace_pc,
    output logic [4:0]             trace_addr,
    output logic [31:0]            trace_data,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] count
);
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trace_rec_t;

    trace_rec_t  push_rec;
    trace_rec_t  head_rec;
    logic        fifo_in_rdy;
    logic        fifo_full;
    logic        wr_ok;
    logic [31:0] regs [32];

    // Gated by reset so nothing is written or bypassed while reset is held.
    assign wr_ok    = reset & we & (waddr != 5'd0) & fifo_in_rdy;
    assign push_rec = '{pc: wpc, addr: waddr, data: wdata};

    grf_fifo #(
        .W     ($bits(trace_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk (clk),
        .arst_n   (reset),
        .in_vld   (wr_ok),
        .in_rdy   (fifo_in_rdy),
        .in_dat   (push_rec),
        .out_vld  (trace_valid),
        .out_rdy  (trace_ready),
        .out_dat  (head_rec),
        .count    (count),
        .full     (fifo_full)
    );

    assign stall      = fifo_full;
    assign trace_pc   = head_rec.pc;
    assign trace_addr = head_rec.addr;
    assign trace_data = head_rec.data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != 5'd0) rdata1 = (wr_ok && waddr == raddr1) ? wdata : regs[raddr1];
        if (raddr2 != 5'd0) rdata2 = (wr_ok && waddr == raddr2) ? wdata : regs[raddr2];
    end
endmodule

// File: tb/tb_grf_trace.sv
// Bench for grf_trace: directed vector table, reset corner sequences and a random phase,
// with a reference register model and a scoreboard queue of expected trace records.
module tb_grf_trace;
    localparam int DEPTH = 4;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        rdy;
        logic [31:0] e_rd1;
        int          e_cnt;
        logic        e_stall;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] wpc;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic        stall;
    logic [2:0]  count;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mreg [32];
    rec_t        sbq [$];
    vec_t        vt [18];

    grf_trace #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .wpc         (wpc),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .stall       (stall),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        sbq.delete();
    endtask

    // Drive one cycle at the falling edge, compare just after, then advance the model
    // to the state the DUT reaches on the following rising edge.
    task automatic cycle(input vec_t v, input bit use_exp);
        logic        mstall;
        logic        mpop;
        logic        mwr;
        logic [31:0] e1;
        logic [31:0] e2;
        rec_t        r;
        @(negedge clk);
        we = v.we; waddr = v.wa; wdata = v.wd; wpc = v.pc;
        raddr1 = v.ra1; raddr2 = v.ra2; trace_ready = v.rdy;
        #1;
        mstall = (sbq.size() == DEPTH);
        mpop   = (sbq.size() != 0) && v.rdy;
        mwr    = v.we && (v.wa != 5'd0) && (!mstall || mpop);
        e1 = (v.ra1 == 5'd0) ? 32'd0 : (mwr && v.wa == v.ra1) ? v.wd : mreg[v.ra1];
        e2 = (v.ra2 == 5'd0) ? 32'd0 : (mwr && v.wa == v.ra2) ? v.wd : mreg[v.ra2];
        chk("rdata1", rdata1, e1);
        chk("rdata2", rdata2, e2);
        chk("count", 32'(count), 32'(sbq.size()));
        chk("stall", 32'(stall), 32'(mstall));
        chk("trace_valid", 32'(trace_valid), 32'(sbq.size() != 0));
        if (use_exp) begin
            chk("tbl_rdata1", rdata1, v.e_rd1);
            chk("tbl_count", 32'(count), 32'(v.e_cnt));
            chk("tbl_stall", 32'(stall), 32'(v.e_stall));
        end
        if (sbq.size() != 0) begin
            r = sbq[0];
            chk("trace_pc", trace_pc, r.pc);
            chk("trace_addr", 32'(trace_addr), 32'(r.addr));
            chk("trace_data", trace_data, r.data);
            if (mpop) void'(sbq.pop_front());
        end
        if (mwr) begin
            mreg[v.wa] = v.wd;
            sbq.push_back('{pc: v.pc, addr: v.wa, data: v.wd});
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                      input logic rdy);
        vec_t v;
        v = '{1'b1, a, d, pc, a, 5'd1, rdy, 32'd0, 0, 1'b0};
        cycle(v, 1'b0);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wpc = '0;
        raddr1 = 5'd5; raddr2 = 5'd0; trace_ready = 1'b0;
        model_clear();

        //            we  wa     wd             pc          ra1    ra2    rdy  e_rd1         cnt stall
        vt[0]  = '{1'b1, 5'd5, 32'h1234,     32'h3000, 5'd5, 5'd0, 1'b0, 32'h1234,     0, 1'b0};
        vt[1]  = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd5, 5'd5, 1'b0, 32'h1234,     1, 1'b0};
        vt[2]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 32'h3004, 5'd0, 5'd5, 1'b0, 32'h0,        1, 1'b0};
        vt[3]  = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd0, 5'd5, 1'b1, 32'h0,        1, 1'b0};
        vt[4]  = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd5, 5'd0, 1'b1, 32'h1234,     0, 1'b0};
        vt[5]  = '{1'b1, 5'd1, 32'h11,       32'h100,  5'd1, 5'd2, 1'b0, 32'h11,       0, 1'b0};
        vt[6]  = '{1'b1, 5'd2, 32'h22,       32'h104,  5'd1, 5'd2, 1'b0, 32'h11,       1, 1'b0};
        vt[7]  = '{1'b1, 5'd3, 32'h33,       32'h108,  5'd3, 5'd3, 1'b0, 32'h33,       2, 1'b0};
        vt[8]  = '{1'b1, 5'd4, 32'h44,       32'h10C,  5'd4, 5'd1, 1'b0, 32'h44,       3, 1'b0};
        vt[9]  = '{1'b1, 5'd6, 32'h66,       32'h110,  5'd6, 5'd6, 1'b0, 32'h0,        4, 1'b1};
        vt[10] = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd6, 5'd4, 1'b0, 32'h0,        4, 1'b1};
        vt[11] = '{1'b1, 5'd7, 32'h77,       32'h114,  5'd7, 5'd7, 1'b1, 32'h77,       4, 1'b1};
        vt[12] = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd7, 5'd6, 1'b0, 32'h77,       4, 1'b1};
        vt[13] = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd7, 5'd0, 1'b1, 32'h77,       4, 1'b1};
        vt[14] = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd2, 5'd0, 1'b1, 32'h22,       3, 1'b0};
        vt[15] = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd3, 5'd0, 1'b1, 32'h33,       2, 1'b0};
        vt[16] = '{1'b1, 5'd8, 32'h88,       32'h118,  5'd8, 5'd7, 1'b1, 32'h88,       1, 1'b0};
        vt[17] = '{1'b0, 5'd0, 32'h0,        32'h0,    5'd8, 5'd8, 1'b0, 32'h88,       1, 1'b0};

        // Reset held across clock edges: outputs idle, and a bypass attempt is gated.
        repeat (2) @(posedge clk);
        #1;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        @(negedge clk);
        we = 1'b0;
        reset = 1'b1;

        foreach (vt[i]) cycle(vt[i], 1'b1);

        // Leave exactly three records pending, then pulse reset between edges.
        v = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 0, 1'b0};
        cycle(v, 1'b0);
        wr(5'd1, 32'hA1, 32'h200, 1'b0);
        wr(5'd2, 32'hA2, 32'h204, 1'b0);
        wr(5'd3, 32'hA3, 32'h208, 1'b0);
        @(negedge clk);
        we = 1'b0; trace_ready = 1'b0; raddr1 = 5'd1; raddr2 = 5'd2;
        #1;
        chk("pre_rst_count", 32'(count), 32'd3);
        #1;
        reset = 1'b0;
        we = 1'b1; waddr = 5'd1; wdata = 32'hBAD0_0001;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(trace_valid), 32'd0);
        chk("midrst_rdata1", rdata1, 32'd0);
        chk("midrst_rdata2", rdata2, 32'd0);
        raddr1 = 5'd3;
        #1;
        chk("midrst_rdata3", rdata1, 32'd0);
        we = 1'b0;
        #1;
        reset = 1'b1;
        model_clear();

        // Idle pops on an empty FIFO.
        for (int i = 0; i < 3; i++) begin
            v = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd3, 1'b1, 32'h0, 0, 1'b0};
            cycle(v, 1'b1);
        end

        // First record after reset, then drain it.
        wr(5'd9, 32'h99, 32'h300, 1'b0);
        v = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9, 1'b1, 32'h99, 1, 1'b0};
        cycle(v, 1'b1);

        // Random traffic with bursts of backpressure.
        for (int i = 0; i < 200; i++) begin
            v.we  = 1'($urandom_range(0, 1));
            v.wa  = 5'($urandom_range(0, 7));
            v.wd  = $urandom;
            v.pc  = 32'h4000 + 32'(i * 4);
            v.ra1 = 5'($urandom_range(0, 7));
            v.ra2 = 5'($urandom_range(0, 7));
            v.rdy = ((i / 20) % 2 == 0) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0);
            v.e_rd1 = '0; v.e_cnt = 0; v.e_stall = 1'b0;
            cycle(v, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
